// File: rtl/affine_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : affine_addr_gen
//  Purpose  : Multi-dimensional affine address scanner (odometer order) with
//             valid/ready output and incremental offset generation.
//  Revision : 1.0 - initial release
// ============================================================================
module affine_addr_gen #(
  parameter int NDIM   = 3,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDR_W-1:0]      base,
  input  logic [NDIM*CNT_W-1:0]  extent,
  input  logic [NDIM*ADDR_W-1:0] stride,
  output logic                   addr_valid,
  input  logic                   addr_ready,
  output logic [ADDR_W-1:0]      addr,
  output logic                   addr_last,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t r_state, w_state_next;

  logic [ADDR_W-1:0]             r_base;
  logic [ADDR_W-1:0]             r_addr;
  logic [ADDR_W-1:0]             w_addr_next;
  logic [NDIM-1:0][CNT_W-1:0]    r_max;
  logic [NDIM-1:0][CNT_W-1:0]    r_idx;
  logic [NDIM-1:0][CNT_W-1:0]    w_idx_next;
  logic [NDIM-1:0][CNT_W-1:0]    w_in_max;
  logic [NDIM-1:0][ADDR_W-1:0]   r_stride;
  logic [NDIM-1:0][ADDR_W-1:0]   r_off;
  logic [NDIM-1:0][ADDR_W-1:0]   w_off_next;
  logic [NDIM-1:0]               w_wrap;
  logic [NDIM-1:0]               w_carry;
  logic [NDIM-1:0]               w_at_max;
  logic                          r_last;
  logic                          r_done;
  logic                          w_start;
  logic                          w_xfer;
  logic                          w_final;
  logic                          w_advance;

  assign w_start   = (r_state == IDLE) && start;
  assign w_xfer    = (r_state == RUN) && addr_ready;
  assign w_final   = w_xfer && r_last && !abort;
  assign w_advance = w_xfer && !r_last && !abort;

  // Per-dimension odometer step; carry is a flat AND of lower wraps to keep
  // the combinational graph acyclic.
  for (genvar d = 0; d < NDIM; d++) begin : g_dim
    logic [CNT_W-1:0] w_ext;
    assign w_ext       = extent[d*CNT_W +: CNT_W];
    assign w_in_max[d] = (w_ext == '0) ? '0 : w_ext - CNT_W'(1);
    assign w_wrap[d]   = (r_idx[d] == r_max[d]);

    if (d == 0) begin : g_carry0
      assign w_carry[d] = 1'b1;
    end else begin : g_carryn
      assign w_carry[d] = &w_wrap[d-1:0];
    end

    assign w_idx_next[d] = !w_carry[d] ? r_idx[d] :
                           (w_wrap[d] ? '0 : r_idx[d] + CNT_W'(1));
    assign w_off_next[d] = !w_carry[d] ? r_off[d] :
                           (w_wrap[d] ? '0 : r_off[d] + r_stride[d]);
    assign w_at_max[d]   = (w_idx_next[d] == r_max[d]);
  end

  always_comb begin
    w_addr_next = r_base;
    for (int d = 0; d < NDIM; d++) begin
      w_addr_next = w_addr_next + w_off_next[d];
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (abort || w_final) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base   <= '0;
      r_addr   <= '0;
      r_max    <= '0;
      r_idx    <= '0;
      r_stride <= '0;
      r_off    <= '0;
      r_last   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_final;
      if (w_start) begin
        r_base   <= base;
        r_addr   <= base;
        r_max    <= w_in_max;
        r_stride <= stride;
        r_idx    <= '0;
        r_off    <= '0;
        r_last   <= (w_in_max == '0);
      end else if (w_advance) begin
        r_idx  <= w_idx_next;
        r_off  <= w_off_next;
        r_addr <= w_addr_next;
        r_last <= &w_at_max;
      end
    end
  end

  assign addr_valid = (r_state == RUN);
  assign busy       = (r_state == RUN);
  assign addr       = r_addr;
  assign addr_last  = r_last && (r_state == RUN);
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_affine_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_affine_addr_gen
//  Purpose  : Directed self-checking bench for affine_addr_gen (NDIM=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_affine_addr_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] base;
  logic [47:0] extent;
  logic [95:0] stride;
  logic        addr_valid;
  logic        addr_ready;
  logic [31:0] addr;
  logic        addr_last;
  logic        busy;
  logic        done;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  affine_addr_gen #(
    .NDIM   (3),
    .ADDR_W (32),
    .CNT_W  (16)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .base       (base),
    .extent     (extent),
    .stride     (stride),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr       (addr),
    .addr_last  (addr_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(addr_valid), 32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_last"},  32'(addr_last),  32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
  endtask

  // Called at a negedge. mode 0: ready=1; mode 1: ready 1,0,0,...;
  // mode 2: ready=1 with start held high during the scan.
  task automatic do_scan(input logic [31:0] b, input logic [47:0] ext,
                         input logic [95:0] str, input int mode, input bit tail);
    int k;
    int cyc;
    int n;
    n          = exp_q.size();
    base       = b;
    extent     = ext;
    stride     = str;
    start      = 1'b1;
    addr_ready = 1'b0;
    @(posedge clk); #1;
    start  = 1'b0;
    base   = ~b;
    extent = '0;
    stride = ~str;
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 200) begin
      addr_ready = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
      start      = (mode == 2);
      @(negedge clk);
      check("valid", 32'(addr_valid), 32'd1);
      check("busy",  32'(busy),       32'd1);
      check("done_run", 32'(done),    32'd0);
      check("addr",  addr,            exp_q[k]);
      check("last",  32'(addr_last),  32'(k == n - 1));
      if (addr_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    if (k < n) check("timeout", 32'(k), 32'(n));
    @(negedge clk);
    check("end_valid", 32'(addr_valid), 32'd0);
    check("end_busy",  32'(busy),       32'd0);
    check("end_done",  32'(done),       32'd1);
    if (tail) begin
      @(posedge clk); #1;
      @(negedge clk);
      check_idle_outputs("post");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    addr_ready = 1'b0;
    base       = '0;
    extent     = '0;
    stride     = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    check("rst_addr", addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("idle");

    // 2-D scan, full throughput
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h140, 32'h144, 32'h148};
    do_scan(32'h100, {16'd1, 16'd2, 16'd3}, {32'h0, 32'h40, 32'h4}, 0, 1'b1);

    // Same scan with stalls, then a new start in the done cycle
    do_scan(32'h100, {16'd1, 16'd2, 16'd3}, {32'h0, 32'h40, 32'h4}, 1, 1'b0);
    exp_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    do_scan(32'hFFFF_FFFC, {16'd1, 16'd1, 16'd3}, {32'h5678, 32'h1234, 32'h4}, 0, 1'b1);

    // Negative stride, start held high during RUN must be ignored
    exp_q = '{32'h20, 32'h18, 32'h10};
    do_scan(32'h20, {16'd1, 16'd1, 16'd3}, {32'h0, 32'h0, 32'hFFFF_FFF8}, 2, 1'b1);

    // All extents zero: one beat
    exp_q = '{32'h555};
    do_scan(32'h555, 48'h0, {32'h9, 32'h8, 32'h7}, 0, 1'b1);

    // 3-D odometer with stalls
    exp_q = '{32'h1000, 32'h1001, 32'h1010, 32'h1011,
              32'h1100, 32'h1101, 32'h1110, 32'h1111};
    do_scan(32'h1000, {16'd2, 16'd2, 16'd2}, {32'h100, 32'h10, 32'h1}, 1, 1'b1);

    // Abort on the third beat, then restart
    base       = 32'h100;
    extent     = {16'd1, 16'd2, 16'd3};
    stride     = {32'h0, 32'h40, 32'h4};
    start      = 1'b1;
    addr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    check("abort_beat_addr",  addr,             32'h108);
    check("abort_beat_valid", 32'(addr_valid),  32'd1);
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_idle_outputs("abort");
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_no_done", 32'(done), 32'd0);
    exp_q = '{32'h100, 32'h104, 32'h108, 32'h140, 32'h144, 32'h148};
    do_scan(32'h100, {16'd1, 16'd2, 16'd3}, {32'h0, 32'h40, 32'h4}, 0, 1'b1);

    // start together with abort in IDLE: start wins
    base   = 32'h700;
    extent = '0;
    stride = '0;
    start  = 1'b1;
    abort  = 1'b1;
    addr_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("sa_valid", 32'(addr_valid), 32'd1);
    check("sa_addr",  addr,            32'h700);
    check("sa_last",  32'(addr_last),  32'd1);
    addr_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("sa_done", 32'(done), 32'd1);

    // Asynchronous reset mid-scan
    base       = 32'h100;
    extent     = {16'd1, 16'd2, 16'd3};
    stride     = {32'h0, 32'h40, 32'h4};
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("arst");
    check("arst_addr", addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("arst_wait");
    do_scan(32'h100, {16'd1, 16'd2, 16'd3}, {32'h0, 32'h40, 32'h4}, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
